// File: rtl/key_ctrl_module.sv
// Key debounce and press sequencer: turns edge-detector pulses plus the raw pin
// into clean press/release/long-press events and a stable key level.
module key_ctrl_module #(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int LONG_CYC     = 50_000_000,
  parameter int CNT_W        = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_in,
  input  logic h2l_sig,
  input  logic l2h_sig,
  output logic key_press,
  output logic key_release,
  output logic key_long,
  output logic key_level,
  output logic busy
);

  typedef enum logic [1:0] {IDLE, DB_PRESS, PRESSED, DB_REL} state_t;

  localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_END   = CNT_W'(LONG_CYC - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] settle_cnt, settle_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_nxt;
  logic             long_fired, long_fired_nxt;
  logic             press_nxt, release_nxt, long_nxt, level_nxt, busy_nxt;
  logic             edge_seen;

  assign edge_seen = h2l_sig | l2h_sig;

  always_comb begin
    state_nxt      = state;
    settle_nxt     = settle_cnt;
    hold_nxt       = hold_cnt;
    long_fired_nxt = long_fired;
    press_nxt      = 1'b0;
    release_nxt    = 1'b0;
    long_nxt       = 1'b0;
    level_nxt      = key_level;
    case (state)
      IDLE: begin
        if (h2l_sig) begin
          state_nxt  = DB_PRESS;
          settle_nxt = '0;
        end
      end
      DB_PRESS: begin
        // A fresh edge inside the window wins over the end-of-window sample.
        if (edge_seen) settle_nxt = '0;
        else if (settle_cnt == SETTLE_END) begin
          if (!pin_in) begin
            state_nxt      = PRESSED;
            press_nxt      = 1'b1;
            level_nxt      = 1'b1;
            hold_nxt       = '0;
            long_fired_nxt = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end else settle_nxt = settle_cnt + CNT_W'(1);
      end
      PRESSED: begin
        if (hold_cnt == HOLD_END) begin
          if (!long_fired) begin
            long_nxt       = 1'b1;
            long_fired_nxt = 1'b1;
          end
        end else hold_nxt = hold_cnt + CNT_W'(1);
        if (l2h_sig) begin
          state_nxt  = DB_REL;
          settle_nxt = '0;
        end
      end
      DB_REL: begin
        if (edge_seen) settle_nxt = '0;
        else if (settle_cnt == SETTLE_END) begin
          if (pin_in) begin
            state_nxt   = IDLE;
            release_nxt = 1'b1;
            level_nxt   = 1'b0;
          end else begin
            state_nxt = PRESSED;
          end
        end else settle_nxt = settle_cnt + CNT_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt == DB_PRESS) || (state_nxt == DB_REL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      settle_cnt  <= '0;
      hold_cnt    <= '0;
      long_fired  <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
      key_level   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      settle_cnt  <= settle_nxt;
      hold_cnt    <= hold_nxt;
      long_fired  <= long_fired_nxt;
      key_press   <= press_nxt;
      key_release <= release_nxt;
      key_long    <= long_nxt;
      key_level   <= level_nxt;
      busy        <= busy_nxt;
    end
  end

endmodule
